// File: rtl/aes_lite_core.sv
// Iterative toy SPN block cipher, one round per enabled clock, with a start/busy/done handshake.
// The decrypt datapath is built only when AES_LITE_DEC_EN is defined; otherwise the core always encrypts.
module aes_lite_core #(
  parameter int unsigned NBYTES = 1,
  parameter int unsigned ROUNDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  start,
  input  logic                  mode,
  input  logic [8*NBYTES-1:0]   din,
  input  logic [8*NBYTES-1:0]   key,
  output logic [8*NBYTES-1:0]   dout,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            round_idx
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned NNIB = 2 * NBYTES;
  localparam logic [3:0]  LAST = 4'(ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_s;
  logic [W-1:0]   r_key;
  logic [W-1:0]   r_dout;
  logic [3:0]     r_round;
  logic           r_busy;
  logic           r_done;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    case (x)
      4'h0: sbox4 = 4'hC;  4'h1: sbox4 = 4'h5;  4'h2: sbox4 = 4'h6;  4'h3: sbox4 = 4'hB;
      4'h4: sbox4 = 4'h9;  4'h5: sbox4 = 4'h0;  4'h6: sbox4 = 4'hA;  4'h7: sbox4 = 4'hD;
      4'h8: sbox4 = 4'h3;  4'h9: sbox4 = 4'hE;  4'hA: sbox4 = 4'hF;  4'hB: sbox4 = 4'h8;
      4'hC: sbox4 = 4'h4;  4'hD: sbox4 = 4'h7;  4'hE: sbox4 = 4'h1;  default: sbox4 = 4'h2;
    endcase
  endfunction

  function automatic logic [W-1:0] sub_bytes(input logic [W-1:0] x);
    logic [W-1:0] y;
    for (int i = 0; i < NNIB; i++) y[4*i +: 4] = sbox4(x[4*i +: 4]);
    return y;
  endfunction

  // Amount is always < W, so the complementary shift never exceeds W.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int unsigned n);
    return (x << n) | (x >> (W - n));
  endfunction

  function automatic logic [W-1:0] round_key(input logic [W-1:0] k, input logic [3:0] r);
    return rotl(k, 32'(r) % W) ^ W'(r);
  endfunction

  logic [W-1:0] w_enc_next;
  logic [W-1:0] w_next;
  logic [W-1:0] w_load;
  logic [3:0]   w_first;
  logic [3:0]   w_idx_next;
  logic         w_last;

  assign w_enc_next = rotl(sub_bytes(r_s), 1) ^ round_key(r_key, r_round);

`ifdef AES_LITE_DEC_EN
  logic         r_mode;
  logic [W-1:0] w_dec_core;
  logic [W-1:0] w_dec_next;

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    case (x)
      4'hC: inv_sbox4 = 4'h0;  4'h5: inv_sbox4 = 4'h1;  4'h6: inv_sbox4 = 4'h2;  4'hB: inv_sbox4 = 4'h3;
      4'h9: inv_sbox4 = 4'h4;  4'h0: inv_sbox4 = 4'h5;  4'hA: inv_sbox4 = 4'h6;  4'hD: inv_sbox4 = 4'h7;
      4'h3: inv_sbox4 = 4'h8;  4'hE: inv_sbox4 = 4'h9;  4'hF: inv_sbox4 = 4'hA;  4'h8: inv_sbox4 = 4'hB;
      4'h4: inv_sbox4 = 4'hC;  4'h7: inv_sbox4 = 4'hD;  4'h1: inv_sbox4 = 4'hE;  default: inv_sbox4 = 4'hF;
    endcase
  endfunction

  function automatic logic [W-1:0] inv_sub_bytes(input logic [W-1:0] x);
    logic [W-1:0] y;
    for (int i = 0; i < NNIB; i++) y[4*i +: 4] = inv_sbox4(x[4*i +: 4]);
    return y;
  endfunction

  // rotr by 1 expressed as rotl by W-1.
  assign w_dec_core = inv_sub_bytes(rotl(r_s ^ round_key(r_key, r_round), W - 1));
  assign w_dec_next = (r_round == 4'd1) ? (w_dec_core ^ r_key) : w_dec_core;
  assign w_next     = r_mode ? w_dec_next : w_enc_next;
  assign w_last     = r_mode ? (r_round == 4'd1) : (r_round == LAST);
  assign w_idx_next = r_mode ? (r_round - 4'd1) : (r_round + 4'd1);
  assign w_load     = mode ? din : (din ^ key);
  assign w_first    = mode ? LAST : 4'd1;
`else
  logic w_unused_mode;

  assign w_unused_mode = mode;
  assign w_next        = w_enc_next;
  assign w_last        = (r_round == LAST);
  assign w_idx_next    = r_round + 4'd1;
  assign w_load        = din ^ key;
  assign w_first       = 4'd1;
`endif

  // Handshake FSM and round state; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_key   <= '0;
      r_dout  <= '0;
      r_round <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef AES_LITE_DEC_EN
      r_mode  <= 1'b0;
`endif
    end else if (ena) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_key   <= key;
`ifdef AES_LITE_DEC_EN
            r_mode  <= mode;
`endif
            r_s     <= w_load;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_round <= w_first;
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_s <= w_next;
          if (w_last) begin
            r_dout  <= w_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_round <= 4'd0;
            r_state <= S_DONE;
          end else begin
            r_round <= w_idx_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout      = r_dout;
  assign busy      = r_busy;
  assign done      = r_done;
  assign round_idx = r_round;

endmodule

// File: tb/tb_aes_lite_core.sv
// Scoreboard bench for aes_lite_core: an 8-bit/4-round instance and a 16-bit/1-round instance,
// each checked against a table-driven reference model of the cipher.
module tb_aes_lite_core;

  localparam int ROUNDS = 4;
`ifdef AES_LITE_DEC_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        start = 1'b0, mode = 1'b0;
  logic [7:0]  din = '0, key = '0, dout;
  logic        busy, done;
  logic [3:0]  round_idx;

  logic        start2 = 1'b0, mode2 = 1'b0;
  logic [15:0] din2 = '0, key2 = '0, dout2;
  logic        busy2, done2;
  logic [3:0]  round_idx2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q[$];
  logic [31:0] q2[$];
  logic prev_done = 1'b0, prev_done2 = 1'b0;

  bit [3:0] SB[16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  aes_lite_core #(.NBYTES(1), .ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode),
    .din(din), .key(key), .dout(dout), .busy(busy), .done(done), .round_idx(round_idx)
  );

  aes_lite_core #(.NBYTES(2), .ROUNDS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start2), .mode(mode2),
    .din(din2), .key(key2), .dout(dout2), .busy(busy2), .done(done2), .round_idx(round_idx2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] m_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic bit [31:0] m_rotl(input bit [31:0] x, input int n, input int w);
    int s = n % w;
    if (s == 0) return x;
    return ((x << s) | (x >> (w - s))) & m_mask(w);
  endfunction

  function automatic bit [31:0] m_sub(input bit [31:0] x, input int w, input bit inv);
    bit [31:0] y = '0;
    bit [3:0] nib;
    for (int i = 0; i < w / 4; i++) begin
      nib = x[4*i +: 4];
      if (!inv) y[4*i +: 4] = SB[nib];
      else for (int j = 0; j < 16; j++) if (SB[j] == nib) y[4*i +: 4] = 4'(j);
    end
    return y;
  endfunction

  function automatic bit [31:0] m_cipher(input bit [31:0] d, input bit [31:0] k, input bit m,
                                         input int nbytes, input int rounds);
    int w = 8 * nbytes;
    bit [31:0] s, rk;
    if (m && DEC) begin
      s = d;
      for (int r = rounds; r >= 1; r--) begin
        rk = m_rotl(k, r, w) ^ 32'(r);
        s  = m_sub(m_rotl(s ^ rk, w - 1, w), w, 1'b1);
        if (r == 1) s = s ^ k;
      end
    end else begin
      s = d ^ k;
      for (int r = 1; r <= rounds; r++) begin
        rk = m_rotl(k, r, w) ^ 32'(r);
        s  = m_rotl(m_sub(s, w, 1'b0), 1, w) ^ rk;
      end
    end
    return s & m_mask(w);
  endfunction

  // Scoreboard monitors: compare on each rising edge of done.
  always @(negedge clk) begin
    if (rst_n && done && !prev_done) begin
      if (q.size() == 0) check("dout_unexpected", 32'(dout), 32'hDEAD_BEEF);
      else check("dout", 32'(dout), q.pop_front());
    end
    prev_done <= done;
  end

  always @(negedge clk) begin
    if (rst_n && done2 && !prev_done2) begin
      if (q2.size() == 0) check("dout2_unexpected", 32'(dout2), 32'hDEAD_BEEF);
      else check("dout2", 32'(dout2), q2.pop_front());
    end
    prev_done2 <= done2;
  end

  task automatic issue(input logic [7:0] d, input logic [7:0] k, input logic m, input logic [7:0] exp);
    din = d; key = k; mode = m; start = 1'b1;
    q.push_back(32'(exp));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input bit chk_idx, input bit dec, input bit drop);
    int n = 0;
    check("busy_after_accept", 32'(busy), 32'd1);
    while (!done && n < 200) begin
      if (chk_idx && busy) check("round_idx", 32'(round_idx), dec ? 32'(ROUNDS - n) : 32'(n + 1));
      if (drop && n == 1) ena = 1'b0;
      if (drop && n == 4) ena = 1'b1;
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("busy_in_done", 32'(busy), 32'd0);
    check("round_idx_in_done", 32'(round_idx), 32'd0);
  endtask

  task automatic run2(input logic [15:0] d, input logic [15:0] k, input logic m, input logic [15:0] exp);
    int n = 0;
    din2 = d; key2 = k; mode2 = m; start2 = 1'b1;
    q2.push_back(32'(exp));
    @(negedge clk);
    start2 = 1'b0;
    while (!done2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("latency2", 32'(n), 32'd1);
  endtask

  initial begin
    logic [7:0] d, k, e;
    logic m;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, k, e;
    logic m;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_round_idx", 32'(round_idx), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero vector and pattern vector, then restart straight from DONE.
    issue(8'h00, 8'h00, 1'b0, 8'h72);
    wait_done(ROUNDS, 1'b1, 1'b0, 1'b0);
    issue(8'hAA, 8'h55, 1'b0, 8'hF3);
    wait_done(ROUNDS, 1'b1, 1'b0, 1'b0);
    issue(8'h00, 8'h00, 1'b0, 8'h72);
    check("done_drop_on_restart", 32'(done), 32'd0);
    wait_done(ROUNDS, 1'b1, 1'b0, 1'b0);

    // Decrypt round trips (or plain encrypt when decrypt is not built).
    issue(8'hF3, 8'h55, 1'b1, DEC ? 8'hAA : 8'(m_cipher(32'hF3, 32'h55, 1'b0, 1, ROUNDS)));
    wait_done(ROUNDS, 1'b1, DEC, 1'b0);
    issue(8'h72, 8'h00, 1'b1, DEC ? 8'h00 : 8'(m_cipher(32'h72, 32'h00, 1'b0, 1, ROUNDS)));
    wait_done(ROUNDS, 1'b1, DEC, 1'b0);
    issue(8'hAA, 8'h55, 1'b1, DEC ? 8'(m_cipher(32'hAA, 32'h55, 1'b1, 1, ROUNDS)) : 8'hF3);
    wait_done(ROUNDS, 1'b1, DEC, 1'b0);

    // start pulse and input changes mid-round must be ignored.
    issue(8'h3C, 8'hA5, 1'b0, 8'(m_cipher(32'h3C, 32'hA5, 1'b0, 1, ROUNDS)));
    din = 8'hFF; key = 8'h11; mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ROUNDS - 1, 1'b0, 1'b0, 1'b0);

    // ena low for three cycles stretches latency by three.
    issue(8'h5A, 8'hC3, 1'b0, 8'(m_cipher(32'h5A, 32'hC3, 1'b0, 1, ROUNDS)));
    wait_done(ROUNDS + 3, 1'b0, 1'b0, 1'b1);

    // Reset during round 2 aborts immediately.
    issue(8'h12, 8'h34, 1'b0, 8'h00);
    @(negedge clk);
    check("round2_idx", 32'(round_idx), 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_round_idx", 32'(round_idx), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic, including back-to-back restarts.
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom); k = 8'($urandom); m = 1'($urandom);
      e = 8'(m_cipher(32'(d), 32'(k), m, 1, ROUNDS));
      issue(d, k, m, e);
      wait_done(ROUNDS, 1'b1, m & DEC, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // 16-bit, single-round instance.
    run2(16'h0000, 16'h0000, 1'b0, 16'h9998);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] d2, k2;
      logic m2;
      d2 = 16'($urandom); k2 = 16'($urandom); m2 = 1'($urandom);
      run2(d2, k2, m2, 16'(m_cipher(32'(d2), 32'(k2), m2, 2, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    check("scoreboard2_drained", 32'(q2.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_lite_core.md
Name: aes_lite_core

Overview:
- Parametrised successor to the single-byte AES-style FSM engine.
- Iterative toy SPN block cipher: one round per clock, width NBYTES*8.
- Start/busy/done handshake; output holds until the next start.
- Sits behind the tt_um top wrapper: top maps ui_in/uio_in onto din/key and drives dout onto uo_out.

Parameters:
- NBYTES, 1, data/key width in bytes; W = 8*NBYTES; legal 1..4.
- ROUNDS, 4, number of rounds; legal 1..15; round counter is 4 bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  clock enable; when 0, all state holds.
- start  in  1  request; sampled only in IDLE or DONE.
- mode  in  1  0 = encrypt, 1 = decrypt (see Optional Feature).
- din  in  W  plaintext/ciphertext; sampled on the accepted start.
- key  in  W  key; sampled on the accepted start.
- dout  out  W  result; valid while done=1.
- busy  out  1  high in ROUND.
- done  out  1  high in DONE.
- round_idx  out  4  current round number; 0 outside ROUND.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, dout=0, busy=0, done=0, round_idx=0, latched key/mode=0. Reset mid-round aborts with no output.
- S-box, per nibble: 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2. Inverse S-box is its exact inverse.
- Round key: rk_r = rotl(K, r mod W) XOR r, where r is zero-extended to W.
- Encrypt:
  - On start, s = din XOR key.
  - For r = 1..ROUNDS: s = rotl(SBOX(s), 1) XOR rk_r.
- Decrypt:
  - On start, s = din.
  - For r = ROUNDS..1: s = INVSBOX(rotr(s XOR rk_r, 1)).
  - The r=1 cycle additionally XORs the latched key into s.
- FSM: IDLE -> ROUND -> DONE.
  - IDLE/DONE with start=1 and ena=1: latch key/mode, load s, clear done, set round_idx (1 for encrypt, ROUNDS for decrypt), go to ROUND.
  - ROUND: one round per enabled edge. round_idx increments for encrypt, decrements for decrypt.
  - After the last round edge: dout = s, go to DONE.
  - DONE: done=1 and dout held until the next accepted start.
- Latency: done=1 exactly ROUNDS enabled edges after the start-accept edge; busy is high for ROUNDS cycles.
- start during ROUND is ignored. din/key changes during ROUND have no effect.
- ena=0 during ROUND freezes state, s and round_idx; the round sequence resumes when ena returns to 1.
- Rotation wraps across the full W bits. XOR and rotation are bitwise only; there are no carries.

Optional Feature:
- Macro: AES_LITE_DEC_EN.
- Defined: mode is honoured and the decrypt datapath (inverse S-box, rotr, descending round keys) is built.
- Undefined: mode is ignored and the block always encrypts. No inverse logic is synthesised; round_idx always ascends.

Test Plan:
- Reset/defaults: NBYTES=1, ROUNDS=4. Hold rst_n=0 -> dout=0x00, busy=0, done=0, round_idx=0.
- Encrypt zero vector: din=0x00, key=0x00, mode=0, 1-cycle start.
  - Intermediate s values 0x98, 0xC5, 0x83, then dout=0x72.
  - done rises 4 edges after accept; round_idx steps 1,2,3,4.
- Encrypt pattern: din=0xAA, key=0x55 -> intermediates 0xEF, 0x73, 0x1E, then dout=0xF3.
  - Restart from DONE with din=0x00, key=0x00 -> done drops on the accept edge, then dout=0x72.
- Decrypt round-trip (AES_LITE_DEC_EN defined):
  - din=0xF3, key=0x55, mode=1 -> dout=0xAA.
  - din=0x72, key=0x00, mode=1 -> dout=0x00; round_idx steps 4,3,2,1.
  - With the macro undefined, mode=1 and din=0xAA, key=0x55 -> dout=0xF3.
- Handshake/boundary:
  - Pulse start and change din mid-round -> result unchanged.
  - Drop ena for 3 cycles mid-round -> result unchanged and latency extended by 3.
  - Assert rst_n=0 during round 2 -> immediate IDLE with all outputs 0.
- Width generalisation: NBYTES=2, ROUNDS=1, din=0x0000, key=0x0000 -> dout = rotl16(0xCCCC,1) XOR 0x0001 = 0x9998.
